param_alu_pipe: RTL and testbench

- N-bit, two-stage pipelined datapath; parametrised, registered successor to the team's fixed 3-bit select/add circuit.
- Four operations: per-bit majority, add with majority-derived carry-in, subtract, and running accumulate.
- valid/ready handshake on both sides; sits between a producer stream and a consumer stream.

---
 rtl/param_alu_pipe_if.sv | 27 ++
 rtl/param_alu_pipe.sv | 151 +++++++++++++++
 tb/tb_param_alu_pipe.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/param_alu_pipe_if.sv
// Handshake and operand bundle for param_alu_pipe: producer side (in_*, operands) and consumer side (out_*).
// The master modport is the environment driving the pipe; the slave modport is the pipe itself.
interface param_alu_pipe_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] c;
    logic [1:0]   mode;
    logic         clear;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] y;
    logic         carry_out;

    modport master (
        output in_valid, a, b, c, mode, clear, out_ready,
        input  in_ready, out_valid, y, carry_out
    );

    modport slave (
        input  in_valid, a, b, c, mode, clear, out_ready,
        output in_ready, out_valid, y, carry_out
    );
endinterface

// File: rtl/param_alu_pipe.sv
// param_alu_pipe: two-stage pipelined N-bit datapath (MAJ / ADD / ACC / SUB) with valid/ready on both sides.
// Optional macro ALU_PIPE_SATURATE_EN: ADD/ACC clamp to all-ones on carry, SUB clamps to zero on borrow.
module param_alu_pipe #(
    parameter int N = 8
) (
    input logic             clk,
    input logic             rst_n,
    param_alu_pipe_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_MAJ = 2'b00,
        MODE_ADD = 2'b01,
        MODE_ACC = 2'b10,
        MODE_SUB = 2'b11
    } aluMode_e;

    localparam int            PW   = $clog2(N + 1);
    localparam logic [PW-1:0] HALF = PW'(N / 2);

    aluMode_e     w_mode;
    logic         w_accept;
    logic         w_s1Load;
    logic         w_s1Advance;
    logic         w_s2Load;

    logic [PW-1:0] w_popC;
    logic          w_cin;
    logic [N-1:0]  w_majY;
    logic [N:0]    w_addSum;
    logic [N:0]    w_subDiff;
    logic [N-1:0]  w_accBase;
    logic [N:0]    w_accSum;
    logic [N-1:0]  w_addY;
    logic [N-1:0]  w_subY;
    logic [N-1:0]  w_accY;
    logic [N-1:0]  w_resY;
    logic          w_resC;

    logic [N-1:0] r_acc;
    logic         r_s1Valid;
    logic [N-1:0] r_s1Y;
    logic         r_s1C;
    logic         r_s2Valid;
    logic [N-1:0] r_s2Y;
    logic         r_s2C;

    assign w_mode = aluMode_e'(bus.mode);

    // in_ready depends only on pipeline state and out_ready, never on in_valid.
    assign w_s2Load    = !r_s2Valid || bus.out_ready;
    assign w_s1Advance = r_s1Valid && w_s2Load;
    assign w_s1Load    = !r_s1Valid || w_s1Advance;
    assign w_accept    = bus.in_valid && w_s1Load;

    assign bus.in_ready  = w_s1Load;
    assign bus.out_valid = r_s2Valid;
    assign bus.y         = r_s2Y;
    assign bus.carry_out = r_s2C;

    always_comb begin
        w_popC = '0;
        for (int i = 0; i < N; i++) begin
            w_popC = w_popC + {{(PW-1){1'b0}}, bus.c[i]};
        end
    end

    // A tie (exactly N/2 ones) must not produce a carry-in.
    assign w_cin  = (w_popC > HALF);
    assign w_majY = (bus.a & bus.b) | (bus.a & bus.c) | (bus.b & bus.c);

    assign w_addSum  = {1'b0, bus.a} + {1'b0, bus.b} + {{N{1'b0}}, w_cin};
    assign w_subDiff = {1'b0, bus.a} - {1'b0, bus.b};
    assign w_accBase = bus.clear ? '0 : r_acc;
    assign w_accSum  = {1'b0, w_accBase} + {1'b0, bus.a};

`ifdef ALU_PIPE_SATURATE_EN
    assign w_addY = w_addSum[N]  ? '1 : w_addSum[N-1:0];
    assign w_subY = w_subDiff[N] ? '0 : w_subDiff[N-1:0];
    assign w_accY = w_accSum[N]  ? '1 : w_accSum[N-1:0];
`else
    assign w_addY = w_addSum[N-1:0];
    assign w_subY = w_subDiff[N-1:0];
    assign w_accY = w_accSum[N-1:0];
`endif

    always_comb begin
        w_resY = w_majY;
        w_resC = 1'b0;
        case (w_mode)
            MODE_MAJ: begin
                w_resY = w_majY;
                w_resC = 1'b0;
            end
            MODE_ADD: begin
                w_resY = w_addY;
                w_resC = w_addSum[N];
            end
            MODE_ACC: begin
                w_resY = w_accY;
                w_resC = w_accSum[N];
            end
            MODE_SUB: begin
                w_resY = w_subY;
                w_resC = w_subDiff[N];
            end
            default: begin
                w_resY = w_majY;
                w_resC = 1'b0;
            end
        endcase
    end

    // Accumulator advances at accept time so back-to-back ACC ops chain without a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_accept && (w_mode == MODE_ACC)) begin
            r_acc <= w_accY;
        end else if (bus.clear) begin
            r_acc <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1Valid <= 1'b0;
            r_s1Y     <= '0;
            r_s1C     <= 1'b0;
        end else if (w_s1Load) begin
            r_s1Valid <= w_accept;
            if (w_accept) begin
                r_s1Y <= w_resY;
                r_s1C <= w_resC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2Valid <= 1'b0;
            r_s2Y     <= '0;
            r_s2C     <= 1'b0;
        end else if (w_s2Load) begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_s2Y <= r_s1Y;
                r_s2C <= r_s1C;
            end
        end
    end
endmodule

// File: tb/tb_param_alu_pipe.sv
// Directed self-checking bench for param_alu_pipe (N=8): latency, each mode, cin tie, ACC chaining/clear,
// backpressure ordering and mid-stream reset. Expectations follow ALU_PIPE_SATURATE_EN when defined.
module tb_param_alu_pipe;
    localparam int N = 8;
    localparam logic [1:0] MAJ = 2'b00, ADD = 2'b01, ACC = 2'b10, SUB = 2'b11;

    logic clk;
    logic rst_n;
    int   assertCount;
    int   failCount;
    logic [N:0] resultQ[$];

    param_alu_pipe_if #(.N(N)) bus ();

    param_alu_pipe #(.N(N)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Results are captured at the falling edge, one half-cycle before the transfer edge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            resultQ.push_back({bus.carry_out, bus.y});
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Presents one transaction and holds it until the handshake completes; returns at posedge+1.
    task automatic applyStimulus(input logic [1:0] mode, input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic [N-1:0] c, input logic clr);
        bit done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.mode     = mode;
        bus.a        = a;
        bus.b        = b;
        bus.c        = c;
        bus.clear    = clr;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) checkOutput("acceptTimeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
        bus.clear    = 1'b0;
    endtask

    task automatic waitResult(input string tag, input logic [N-1:0] expY, input logic expC);
        logic [N:0] r;
        for (int i = 0; i < 30 && resultQ.size() == 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (resultQ.size() == 0) begin
            checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            r = resultQ.pop_front();
            checkOutput({tag, "_y"}, 32'(r[N-1:0]), 32'(expY));
            checkOutput({tag, "_carry"}, 32'(r[N]), 32'(expC));
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [N-1:0] expSat;
        assertCount  = 0;
        failCount    = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.c        = '0;
        bus.mode     = MAJ;
        bus.clear    = 1'b0;
        bus.out_ready = 1'b1;
        idleCycles(3);

        checkOutput("resetOutValid", 32'(bus.out_valid), 32'd0);
        checkOutput("resetY", 32'(bus.y), 32'd0);
        checkOutput("resetCarry", 32'(bus.carry_out), 32'd0);
        checkOutput("resetInReady", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        idleCycles(1);

        // Latency: result visible after the second edge following the accept.
        bus.in_valid = 1'b1;
        bus.mode = MAJ; bus.a = 8'hF0; bus.b = 8'hCC; bus.c = 8'hAA;
        @(negedge clk);
        checkOutput("majInReady", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checkOutput("majLatency1", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        checkOutput("majLatency2", 32'(bus.out_valid), 32'd1);
        checkOutput("majYDirect", 32'(bus.y), 32'hE8);
        waitResult("maj", 8'hE8, 1'b0);

        applyStimulus(ADD, 8'h10, 8'h20, 8'h1F, 1'b0);
        waitResult("addCin", 8'h31, 1'b0);
        applyStimulus(ADD, 8'hFF, 8'h00, 8'h0F, 1'b0);
        waitResult("addTie", 8'hFF, 1'b0);
`ifdef ALU_PIPE_SATURATE_EN
        expSat = 8'hFF;
`else
        expSat = 8'h10;
`endif
        applyStimulus(ADD, 8'hF0, 8'h20, 8'h00, 1'b0);
        waitResult("addCarry", expSat, 1'b1);
`ifdef ALU_PIPE_SATURATE_EN
        expSat = 8'h00;
`else
        expSat = 8'hFE;
`endif
        applyStimulus(SUB, 8'h05, 8'h07, 8'h00, 1'b0);
        waitResult("subBorrow", expSat, 1'b1);
        applyStimulus(SUB, 8'h07, 8'h05, 8'h00, 1'b0);
        waitResult("subPlain", 8'h02, 1'b0);

        // Back-to-back ACC ops, then clear coinciding with an ACC accept.
        applyStimulus(ACC, 8'hF0, 8'h00, 8'h00, 1'b0);
        applyStimulus(ACC, 8'h20, 8'h00, 8'h00, 1'b0);
        applyStimulus(ACC, 8'h03, 8'h00, 8'h00, 1'b1);
`ifdef ALU_PIPE_SATURATE_EN
        expSat = 8'hFF;
`else
        expSat = 8'h10;
`endif
        waitResult("acc1", 8'hF0, 1'b0);
        waitResult("acc2", expSat, 1'b1);
        waitResult("accClear", 8'h03, 1'b0);

        // Standalone clear pulse, then ACC must start from zero.
        bus.clear = 1'b1;
        idleCycles(1);
        bus.clear = 1'b0;
        applyStimulus(ACC, 8'h05, 8'h00, 8'h00, 1'b0);
        waitResult("accAfterClear", 8'h05, 1'b0);

        // Backpressure: two accepts fill the pipe, the third must stall.
        bus.out_ready = 1'b0;
        applyStimulus(MAJ, 8'hFF, 8'h0F, 8'h00, 1'b0);
        applyStimulus(MAJ, 8'hF0, 8'hFF, 8'h00, 1'b0);
        bus.in_valid = 1'b1;
        bus.mode = MAJ; bus.a = 8'h3C; bus.b = 8'hFF; bus.c = 8'h00;
        @(negedge clk);
        checkOutput("bpInReadyLow", 32'(bus.in_ready), 32'd0);
        checkOutput("bpOutValid", 32'(bus.out_valid), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("bpInReadyStillLow", 32'(bus.in_ready), 32'd0);
        checkOutput("bpYStable", 32'(bus.y), 32'h0F);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        applyStimulus(MAJ, 8'h3C, 8'hFF, 8'h00, 1'b0);
        applyStimulus(MAJ, 8'h81, 8'h01, 8'hFF, 1'b0);
        waitResult("bp1", 8'h0F, 1'b0);
        waitResult("bp2", 8'hF0, 1'b0);
        waitResult("bp3", 8'h3C, 1'b0);
        waitResult("bp4", 8'h81, 1'b0);
        idleCycles(4);
        checkOutput("bpNoExtra", 32'(resultQ.size()), 32'd0);

        // Mid-stream reset discards in-flight results and zeroes the accumulator.
        bus.out_ready = 1'b0;
        applyStimulus(ACC, 8'h11, 8'h00, 8'h00, 1'b0);
        applyStimulus(ACC, 8'h22, 8'h00, 8'h00, 1'b0);
        rst_n = 1'b0;
        idleCycles(1);
        checkOutput("rstOutValid", 32'(bus.out_valid), 32'd0);
        checkOutput("rstY", 32'(bus.y), 32'd0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        idleCycles(4);
        checkOutput("rstNoEmit", 32'(resultQ.size()), 32'd0);
        applyStimulus(ACC, 8'h07, 8'h00, 8'h00, 1'b0);
        waitResult("rstAccZero", 8'h07, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
